charbuf_writer: RTL and testbench

- Write-side front end for the character buffer scanned by the VGA renderer.
- Accepts single-cycle register writes from the 6502 bus bridge and keeps a text cursor.
- Converts cursor (x, y) to a linear cell address and drives the renderer's character-RAM write port.
- Provides a hardware clear-screen sequencer that walks every cell, so the CPU never loops over 7500 cells.

---
 rtl/gpu_pkg.sv | 33 +++
 rtl/charbuf_writer_if.sv | 35 +++
 rtl/charbuf_cursor.sv | 67 ++++++
 rtl/charbuf_writer.sv | 187 ++++++++++++++++++
 tb/tb_charbuf_writer.sv | 248 ++++++++++++++++++++++++
 5 files changed

// File: rtl/gpu_pkg.sv
// gpu_pkg
// Shared constants for the text-mode GPU: screen geometry, the character
// buffer register map seen by the 6502 bus bridge, CTRL bit positions and
// the writer FSM state encoding. The renderer imports the same geometry.
// No ports (package).

package gpu_pkg;

   // Screen geometry and character-RAM sizing (2^ADDR_BITS >= COLS*ROWS)
   localparam int COLS      = 100;
   localparam int ROWS      = 75;
   localparam int CELL_BITS = 2;
   localparam int ADDR_BITS = 13;

   // Register offsets on the CPU side
   localparam logic [1:0] REG_DATA     = 2'd0;
   localparam logic [1:0] REG_CURSOR_X = 2'd1;
   localparam logic [1:0] REG_CURSOR_Y = 2'd2;
   localparam logic [1:0] REG_CTRL     = 2'd3;

   // CTRL register bit positions
   localparam int CTRL_CLEAR_BIT     = 0;
   localparam int CTRL_OVR_ACK_BIT   = 1;
   localparam int CTRL_FILL_LSB      = 2;
   localparam int CTRL_FILL_LOAD_BIT = 7;

   // Writer FSM
   typedef enum logic {
      IDLE  = 1'b0,
      CLEAR = 1'b1
   } charbuf_state_t;

endpackage

// File: rtl/charbuf_writer_if.sv
// charbuf_writer_if
// Bundles the CPU register-access port and the character-RAM write port of
// the character buffer writer.
//   CPU_STB/CPU_WE/CPU_ADDR/CPU_DIN : register access from the bus bridge
//   CPU_DOUT                        : registered read data
//   FB_WE/FB_ADDR/FB_DATA           : character-RAM write port to renderer
//   BUSY                            : clear sequence in progress
// Modports: master = CPU/bench side, slave = charbuf_writer.

interface charbuf_writer_if #(
   parameter int CELL_BITS = gpu_pkg::CELL_BITS,
   parameter int ADDR_BITS = gpu_pkg::ADDR_BITS
);

   logic                 CPU_STB;
   logic                 CPU_WE;
   logic [1:0]           CPU_ADDR;
   logic [7:0]           CPU_DIN;
   logic [7:0]           CPU_DOUT;
   logic                 FB_WE;
   logic [ADDR_BITS-1:0] FB_ADDR;
   logic [CELL_BITS-1:0] FB_DATA;
   logic                 BUSY;

   modport master (
      output CPU_STB, CPU_WE, CPU_ADDR, CPU_DIN,
      input  CPU_DOUT, FB_WE, FB_ADDR, FB_DATA, BUSY
   );

   modport slave (
      input  CPU_STB, CPU_WE, CPU_ADDR, CPU_DIN,
      output CPU_DOUT, FB_WE, FB_ADDR, FB_DATA, BUSY
   );

endinterface

// File: rtl/charbuf_cursor.sv
// charbuf_cursor
// Text cursor for the character buffer: holds (x, y), clamps CPU-written
// coordinates to the screen, auto-advances with row and screen wrap after
// each DATA write, and exposes the linear cell address y*COLS + x.
// Ports:
//   clk, rst_n     : clock, synchronous active-low reset
//   set_x, set_y   : load x / y from din (clamped)
//   din            : CPU write data
//   advance        : step the cursor one cell
//   home           : force cursor to (0, 0); highest priority
//   x, y           : current cursor
//   lin_addr       : y*COLS + x at ADDR_BITS width

module charbuf_cursor #(
   parameter int COLS      = gpu_pkg::COLS,
   parameter int ROWS      = gpu_pkg::ROWS,
   parameter int ADDR_BITS = gpu_pkg::ADDR_BITS,
   parameter int X_BITS    = $clog2(COLS),
   parameter int Y_BITS    = $clog2(ROWS)
)(
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic                 set_x,
   input  logic                 set_y,
   input  logic [7:0]           din,
   input  logic                 advance,
   input  logic                 home,
   output logic [X_BITS-1:0]    x,
   output logic [Y_BITS-1:0]    y,
   output logic [ADDR_BITS-1:0] lin_addr
);

   localparam logic [7:0]        COLS_LIM = 8'(COLS);
   localparam logic [7:0]        ROWS_LIM = 8'(ROWS);
   localparam logic [X_BITS-1:0] X_LAST   = X_BITS'(COLS - 1);
   localparam logic [Y_BITS-1:0] Y_LAST   = Y_BITS'(ROWS - 1);

   // The writer never asserts more than one of home/set_x/set_y/advance in a
   // cycle, so the priority order only matters for robustness. Out-of-range
   // coordinates clamp to the last column/row rather than wrapping, so a
   // stray large value still lands on screen.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         x <= '0;
         y <= '0;
      end else if (home) begin
         x <= '0;
         y <= '0;
      end else if (set_x) begin
         x <= (din >= COLS_LIM) ? X_LAST : din[X_BITS-1:0];
      end else if (set_y) begin
         y <= (din >= ROWS_LIM) ? Y_LAST : din[Y_BITS-1:0];
      end else if (advance) begin
         if (x == X_LAST) begin
            x <= '0;
            y <= (y == Y_LAST) ? '0 : y + Y_BITS'(1);
         end else begin
            x <= x + X_BITS'(1);
         end
      end
   end

   // Constant multiply; the writer registers the result into FB_ADDR so the
   // strobe-to-address latency stays at one cycle.
   assign lin_addr = ADDR_BITS'(y) * ADDR_BITS'(COLS) + ADDR_BITS'(x);

endmodule

// File: rtl/charbuf_writer.sv
// charbuf_writer
// Write-side front end of the VGA character buffer. Decodes single-cycle
// register accesses from the 6502 bus bridge, keeps a text cursor, drives
// the renderer's character-RAM write port, and runs a hardware clear that
// writes every cell once so the CPU never has to loop over the screen.
// Ports:
//   CLK_PIXEL : pixel clock, the only clock
//   RESET_N   : synchronous active-low reset
//   bus       : charbuf_writer_if.slave (CPU register port, FB write port,
//               BUSY)
// Build option:
//   CHARBUF_FILL_EN : CTRL bit7 loads a fill value from CTRL[CELL_BITS+1:2]
//                     that the clear writes; without it the clear writes 0.

module charbuf_writer
   import gpu_pkg::*;
#(
   parameter int COLS      = gpu_pkg::COLS,
   parameter int ROWS      = gpu_pkg::ROWS,
   parameter int CELL_BITS = gpu_pkg::CELL_BITS,
   parameter int ADDR_BITS = gpu_pkg::ADDR_BITS
)(
   input logic             CLK_PIXEL,
   input logic             RESET_N,
   charbuf_writer_if.slave bus
);

   localparam int                   X_BITS    = $clog2(COLS);
   localparam int                   Y_BITS    = $clog2(ROWS);
   localparam logic [ADDR_BITS-1:0] LAST_ADDR = ADDR_BITS'(COLS * ROWS - 1);

   charbuf_state_t       state;
   logic                 fb_we_q;
   logic [ADDR_BITS-1:0] fb_addr_q;
   logic [CELL_BITS-1:0] fb_data_q;
   logic [7:0]           dout_q;
   logic                 busy_q;
   logic                 overrun_q;

   logic [X_BITS-1:0]    cur_x;
   logic [Y_BITS-1:0]    cur_y;
   logic [ADDR_BITS-1:0] cur_addr;

   logic                 wr_stb;
   logic                 rd_stb;
   logic                 in_clear;
   logic                 data_wr;
   logic                 x_wr;
   logic                 y_wr;
   logic                 ctrl_wr;
   logic                 start_clear;
   logic                 clear_done;
   logic                 drop_wr;
   logic                 fill_load;
   logic [CELL_BITS-1:0] fill_din;
   logic [CELL_BITS-1:0] fill_next;

   // Register decode. Cursor and DATA writes are only honoured while idle;
   // during a clear they are dropped and flagged as an overrun instead.
   assign wr_stb      = bus.CPU_STB && bus.CPU_WE;
   assign rd_stb      = bus.CPU_STB && !bus.CPU_WE;
   assign in_clear    = (state == CLEAR);
   assign data_wr     = wr_stb && (bus.CPU_ADDR == REG_DATA);
   assign x_wr        = wr_stb && (bus.CPU_ADDR == REG_CURSOR_X);
   assign y_wr        = wr_stb && (bus.CPU_ADDR == REG_CURSOR_Y);
   assign ctrl_wr     = wr_stb && (bus.CPU_ADDR == REG_CTRL);
   assign start_clear = ctrl_wr && bus.CPU_DIN[CTRL_CLEAR_BIT] && !in_clear;
   assign clear_done  = in_clear && (fb_addr_q == LAST_ADDR);
   assign drop_wr     = in_clear && (data_wr || x_wr || y_wr);
   assign fill_load   = ctrl_wr && bus.CPU_DIN[CTRL_FILL_LOAD_BIT];
   assign fill_din    = bus.CPU_DIN[CTRL_FILL_LSB +: CELL_BITS];

`ifdef CHARBUF_FILL_EN
   logic [CELL_BITS-1:0] fill_q;

   // Fill value register. A CTRL write that both loads a fill value and
   // starts a clear uses the new value from the very first cell, hence the
   // bypass into fill_next.
   always_ff @(posedge CLK_PIXEL) begin
      if (!RESET_N) begin
         fill_q <= '0;
      end else if (fill_load) begin
         fill_q <= fill_din;
      end
   end

   assign fill_next = fill_load ? fill_din : fill_q;
`else
   logic unused_fill;

   assign unused_fill = fill_load ^ (^fill_din);
   assign fill_next   = '0;
`endif

   // Cursor sub-block: it is parked at (0, 0) on the same edge the clear
   // finishes, so the CPU resumes typing at the top-left corner.
   charbuf_cursor #(
      .COLS      (COLS),
      .ROWS      (ROWS),
      .ADDR_BITS (ADDR_BITS)
   ) u_cursor (
      .clk      (CLK_PIXEL),
      .rst_n    (RESET_N),
      .set_x    (x_wr && !in_clear),
      .set_y    (y_wr && !in_clear),
      .din      (bus.CPU_DIN),
      .advance  (data_wr && !in_clear),
      .home     (clear_done),
      .x        (cur_x),
      .y        (cur_y),
      .lin_addr (cur_addr)
   );

   // Main sequencer. FB_WE/FB_ADDR/FB_DATA are all registered here and have
   // exactly two sources: a DATA write while IDLE, or the sweep while CLEAR.
   // Because the state selects the source, the two can never collide. The
   // sweep reuses fb_addr_q as its cell counter: the start edge writes cell
   // 0 and every CLEAR cycle writes the next one until LAST_ADDR has been
   // written, at which point BUSY and FB_WE drop together.
   // Reads are serviced in any state; CPU_DOUT only changes on a read.
   always_ff @(posedge CLK_PIXEL) begin
      if (!RESET_N) begin
         state     <= IDLE;
         fb_we_q   <= 1'b0;
         fb_addr_q <= '0;
         fb_data_q <= '0;
         dout_q    <= '0;
         busy_q    <= 1'b0;
         overrun_q <= 1'b0;
      end else begin
         if (rd_stb) begin
            case (bus.CPU_ADDR)
               REG_CURSOR_X: dout_q <= 8'(cur_x);
               REG_CURSOR_Y: dout_q <= 8'(cur_y);
               REG_CTRL:     dout_q <= {6'b0, overrun_q, busy_q};
               default:      dout_q <= 8'h00;
            endcase
         end

         if (ctrl_wr && bus.CPU_DIN[CTRL_OVR_ACK_BIT]) begin
            overrun_q <= 1'b0;
         end else if (drop_wr) begin
            overrun_q <= 1'b1;
         end

         case (state)
            IDLE: begin
               fb_we_q <= 1'b0;
               if (start_clear) begin
                  state     <= CLEAR;
                  busy_q    <= 1'b1;
                  fb_we_q   <= 1'b1;
                  fb_addr_q <= '0;
                  fb_data_q <= fill_next;
               end else if (data_wr) begin
                  fb_we_q   <= 1'b1;
                  fb_addr_q <= cur_addr;
                  fb_data_q <= bus.CPU_DIN[CELL_BITS-1:0];
               end
            end
            CLEAR: begin
               if (clear_done) begin
                  state   <= IDLE;
                  busy_q  <= 1'b0;
                  fb_we_q <= 1'b0;
               end else begin
                  fb_we_q   <= 1'b1;
                  fb_addr_q <= fb_addr_q + ADDR_BITS'(1);
                  fb_data_q <= fill_next;
               end
            end
            default: begin
               state   <= IDLE;
               busy_q  <= 1'b0;
               fb_we_q <= 1'b0;
            end
         endcase
      end
   end

   assign bus.FB_WE    = fb_we_q;
   assign bus.FB_ADDR  = fb_addr_q;
   assign bus.FB_DATA  = fb_data_q;
   assign bus.CPU_DOUT = dout_q;
   assign bus.BUSY     = busy_q;

endmodule

// File: tb/tb_charbuf_writer.sv
// tb_charbuf_writer
// Self-checking bench for charbuf_writer. Character-RAM writes are checked
// through a scoreboard queue: every expected write is queued before the
// stimulus that causes it, and each FB_WE pulse pops and compares one entry.
// Register reads are checked directly against bench-computed constants.
// Build option: CHARBUF_FILL_EN (clear writes the loaded fill value 3).

module tb_charbuf_writer;
   import gpu_pkg::*;

   localparam int CELLS = COLS * ROWS;
`ifdef CHARBUF_FILL_EN
   localparam logic [CELL_BITS-1:0] FILL_EXP = 2'd3;
`else
   localparam logic [CELL_BITS-1:0] FILL_EXP = 2'd0;
`endif

   typedef struct packed {
      logic [ADDR_BITS-1:0] addr;
      logic [CELL_BITS-1:0] data;
   } fb_wr_t;

   typedef struct {
      logic                 we;
      logic [1:0]           addr;
      logic [7:0]           din;
      logic                 isRead;
      logic [7:0]           expDout;
      logic                 expWr;
      logic [ADDR_BITS-1:0] expAddr;
      logic [CELL_BITS-1:0] expData;
      string                name;
   } vec_t;

   logic   clk = 1'b0;
   logic   rst_n = 1'b0;
   fb_wr_t expQ[$];
   fb_wr_t expHead;
   vec_t   vecs[$];
   int     passCount = 0;
   int     checkCount = 0;
   int     busyCount = 0;

   always #5 clk = ~clk;

   charbuf_writer_if bus();

   charbuf_writer dut (
      .CLK_PIXEL (clk),
      .RESET_N   (rst_n),
      .bus       (bus)
   );

   // Generic comparison used for register reads and status checks
   task automatic checkOutput(input string name, input logic [31:0] actual,
                              input logic [31:0] expected);
      checkCount++;
      if (actual === expected) passCount++;
      else $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
   endtask

   // Scoreboard consumer: each character-RAM write pops one expected entry
   always @(negedge clk) begin
      if (bus.BUSY === 1'b1) busyCount++;
      if (bus.FB_WE === 1'b1) begin
         checkCount++;
         if (expQ.size() == 0) begin
            $display("[TB] FAIL unexpected_fb_write: got addr %0d data %0d, expected no write",
                     bus.FB_ADDR, bus.FB_DATA);
         end else begin
            expHead = expQ.pop_front();
            if (bus.FB_ADDR === expHead.addr && bus.FB_DATA === expHead.data) passCount++;
            else $display("[TB] FAIL fb_write: got addr %0d data %0d, expected addr %0d data %0d",
                          bus.FB_ADDR, bus.FB_DATA, expHead.addr, expHead.data);
         end
      end
   end

   task automatic pushWrite(input int addr, input logic [CELL_BITS-1:0] data);
      fb_wr_t e;
      e.addr = ADDR_BITS'(addr);
      e.data = data;
      expQ.push_back(e);
   endtask

   // One-cycle register strobe; returns at the negedge after the capturing
   // posedge, when registered outputs from that access are visible.
   task automatic applyStimulus(input logic we, input logic [1:0] addr, input logic [7:0] din);
      @(negedge clk);
      bus.CPU_STB  = 1'b1;
      bus.CPU_WE   = we;
      bus.CPU_ADDR = addr;
      bus.CPU_DIN  = din;
      @(negedge clk);
      bus.CPU_STB  = 1'b0;
      bus.CPU_WE   = 1'b0;
   endtask

   task automatic cpuRead(input logic [1:0] addr, input logic [7:0] expected, input string name);
      applyStimulus(1'b0, addr, 8'h00);
      checkOutput(name, 32'(bus.CPU_DOUT), 32'(expected));
   endtask

   task automatic addVec(input logic we, input logic [1:0] addr, input logic [7:0] din,
                         input logic isRead, input logic [7:0] expDout, input logic expWr,
                         input int expAddr, input logic [CELL_BITS-1:0] expData, input string name);
      vec_t v;
      v.we = we; v.addr = addr; v.din = din; v.isRead = isRead; v.expDout = expDout;
      v.expWr = expWr; v.expAddr = ADDR_BITS'(expAddr); v.expData = expData; v.name = name;
      vecs.push_back(v);
   endtask

   task automatic wrV(input logic [1:0] addr, input logic [7:0] din);
      addVec(1'b1, addr, din, 1'b0, 8'h00, 1'b0, 0, '0, "wr");
   endtask

   task automatic dataV(input logic [7:0] din, input int expAddr, input logic [CELL_BITS-1:0] expData);
      addVec(1'b1, REG_DATA, din, 1'b0, 8'h00, 1'b1, expAddr, expData, "data");
   endtask

   task automatic rdV(input logic [1:0] addr, input logic [7:0] expDout, input string name);
      addVec(1'b0, addr, 8'h00, 1'b1, expDout, 1'b0, 0, '0, name);
   endtask

   // Bounded wait for the clear to finish; an expired budget is a failure
   task automatic waitIdle(input int budget, input string name);
      int n = 0;
      while (bus.BUSY !== 1'b0 && n < budget) begin
         @(negedge clk);
         n++;
      end
      checkOutput(name, 32'(bus.BUSY), 32'd0);
   endtask

   initial begin
      #2_000_000;
      $display("[TB] FAIL watchdog: simulation did not finish in time");
      $fatal(1, "[TB] watchdog expired");
   end

   initial begin
      bus.CPU_STB  = 1'b0;
      bus.CPU_WE   = 1'b0;
      bus.CPU_ADDR = 2'd0;
      bus.CPU_DIN  = 8'h00;
      rst_n        = 1'b0;
      repeat (3) @(negedge clk);

      // Reset state
      checkOutput("reset_fb_we",   32'(bus.FB_WE),    32'd0);
      checkOutput("reset_fb_addr", 32'(bus.FB_ADDR),  32'd0);
      checkOutput("reset_fb_data", 32'(bus.FB_DATA),  32'd0);
      checkOutput("reset_dout",    32'(bus.CPU_DOUT), 32'd0);
      checkOutput("reset_busy",    32'(bus.BUSY),     32'd0);
      rst_n = 1'b1;

      // Register/cursor vectors: writes, reads, clamping and wrap
      dataV(8'h02, 0, 2'd2);
      rdV(REG_CURSOR_X, 8'd1, "x_after_first_data");
      rdV(REG_CURSOR_Y, 8'd0, "y_after_first_data");
      wrV(REG_CURSOR_X, 8'd99);
      wrV(REG_CURSOR_Y, 8'd74);
      rdV(REG_CURSOR_X, 8'd99, "x_set_99");
      rdV(REG_CURSOR_Y, 8'd74, "y_set_74");
      dataV(8'h01, 7499, 2'd1);
      rdV(REG_CURSOR_X, 8'd0, "x_screen_wrap");
      rdV(REG_CURSOR_Y, 8'd0, "y_screen_wrap");
      wrV(REG_CURSOR_X, 8'd200);
      wrV(REG_CURSOR_Y, 8'd80);
      rdV(REG_CURSOR_X, 8'd99, "x_clamp_200");
      rdV(REG_CURSOR_Y, 8'd74, "y_clamp_80");
      dataV(8'h03, 7499, 2'd3);
      rdV(REG_DATA, 8'd0, "data_reads_zero");
      wrV(REG_CURSOR_X, 8'd10);
      wrV(REG_CURSOR_Y, 8'd2);
      dataV(8'h06, 210, 2'd2);
      rdV(REG_CURSOR_X, 8'd11, "x_after_mid_write");
      rdV(REG_CURSOR_Y, 8'd2, "y_after_mid_write");
      rdV(REG_CTRL, 8'h00, "ctrl_idle_reset");
      wrV(REG_CURSOR_X, 8'd99);
      wrV(REG_CURSOR_Y, 8'd0);
      dataV(8'h00, 99, 2'd0);
      rdV(REG_CURSOR_X, 8'd0, "x_row_wrap");
      rdV(REG_CURSOR_Y, 8'd1, "y_row_wrap");
      wrV(REG_CURSOR_X, 8'd100);
      wrV(REG_CURSOR_Y, 8'd75);
      rdV(REG_CURSOR_X, 8'd99, "x_clamp_cols");
      rdV(REG_CURSOR_Y, 8'd74, "y_clamp_rows");

      for (int i = 0; i < vecs.size(); i++) begin
         if (vecs[i].expWr) pushWrite(int'(vecs[i].expAddr), vecs[i].expData);
         applyStimulus(vecs[i].we, vecs[i].addr, vecs[i].din);
         if (vecs[i].isRead)
            checkOutput(vecs[i].name, 32'(bus.CPU_DOUT), 32'(vecs[i].expDout));
      end

      // CPU_DOUT holds the last read value across non-read cycles
      applyStimulus(1'b1, REG_CURSOR_X, 8'd40);
      repeat (3) @(negedge clk);
      checkOutput("dout_hold", 32'(bus.CPU_DOUT), 32'd74);

      // Full clear with mid-clear overrun / ignored restart / overrun ack
      applyStimulus(1'b1, REG_CURSOR_X, 8'd7);
      applyStimulus(1'b1, REG_CURSOR_Y, 8'd3);
      applyStimulus(1'b1, REG_CTRL, 8'h8C);
      cpuRead(REG_CTRL, 8'h00, "ctrl_after_fill_load");
      for (int i = 0; i < CELLS; i++) pushWrite(i, FILL_EXP);
      busyCount = 0;
      applyStimulus(1'b1, REG_CTRL, 8'h01);
      repeat (50) @(negedge clk);
      applyStimulus(1'b1, REG_DATA, 8'h02);
      cpuRead(REG_CTRL, 8'h03, "ctrl_busy_overrun");
      applyStimulus(1'b1, REG_CTRL, 8'h01);
      cpuRead(REG_CTRL, 8'h03, "ctrl_restart_ignored");
      applyStimulus(1'b1, REG_CTRL, 8'h02);
      cpuRead(REG_CTRL, 8'h01, "ctrl_overrun_ack");
      waitIdle(CELLS + 500, "clear_finishes");
      checkOutput("clear_busy_cycles", 32'(busyCount), 32'(CELLS));
      checkOutput("clear_all_cells_written", 32'(expQ.size()), 32'd0);
      cpuRead(REG_CURSOR_X, 8'd0, "x_after_clear");
      cpuRead(REG_CURSOR_Y, 8'd0, "y_after_clear");
      cpuRead(REG_CTRL, 8'h00, "ctrl_after_clear");

      // Reset at clear cycle 100 aborts the sweep
      applyStimulus(1'b1, REG_CURSOR_X, 8'd5);
      applyStimulus(1'b1, REG_CURSOR_Y, 8'd3);
      for (int i = 0; i < 100; i++) pushWrite(i, FILL_EXP);
      applyStimulus(1'b1, REG_CTRL, 8'h01);
      repeat (99) @(negedge clk);
      rst_n = 1'b0;
      @(negedge clk);
      checkOutput("abort_fb_we", 32'(bus.FB_WE), 32'd0);
      checkOutput("abort_busy",  32'(bus.BUSY),  32'd0);
      rst_n = 1'b1;
      repeat (20) @(negedge clk);
      checkOutput("abort_no_more_writes", 32'(expQ.size()), 32'd0);
      checkOutput("abort_still_idle", 32'(bus.BUSY), 32'd0);
      cpuRead(REG_CURSOR_X, 8'd0, "x_after_abort");
      cpuRead(REG_CURSOR_Y, 8'd0, "y_after_abort");

      repeat (5) @(negedge clk);
      checkOutput("scoreboard_empty", 32'(expQ.size()), 32'd0);

      $display("%0d/%0d checks passed", passCount, checkCount);
      $finish;
   end

endmodule
